// File: rtl/conv_read_sched.sv
// Read-side scheduler for SRAM group A: sweeps 2x2-block windows of a 7x7 block map
// in raster order, one bank-rotated 4-bank read per window, under valid/ready.
module conv_read_sched #(
   parameter int unsigned BLK_DIM   = 7,
   parameter int unsigned BANK_COLS = 4,
   parameter int unsigned ADDR_BW   = 6,
   parameter int unsigned STEP_BW   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               out_ready,
   output logic               busy,
   output logic               done,
   output logic [ADDR_BW-1:0] sram_raddr_a0,
   output logic [ADDR_BW-1:0] sram_raddr_a1,
   output logic [ADDR_BW-1:0] sram_raddr_a2,
   output logic [ADDR_BW-1:0] sram_raddr_a3,
   output logic               win_valid,
   output logic [1:0]         win_sel,
   output logic [STEP_BW-1:0] win_oy,
   output logic [STEP_BW-1:0] win_ox
);

   localparam int unsigned LAST_STEP = BLK_DIM - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state;
   logic [STEP_BW-1:0] ny, nx;
   logic               issued;

   logic               stall_c, issue_c, accept_c;
   logic [STEP_BW-1:0] sel_y_c, sel_x_c;

   assign stall_c  = win_valid & ~out_ready;
   assign issue_c  = (state == RUN) & ~stall_c & ~issued;
   assign accept_c = win_valid & out_ready;

   // Address in bank {py,px} of the one neighbourhood block of step (by,bx) that lives there.
   function automatic logic [ADDR_BW-1:0] bank_addr(input logic [STEP_BW-1:0] by,
                                                    input logic [STEP_BW-1:0] bx,
                                                    input logic py,
                                                    input logic px);
      logic [STEP_BW-1:0] r, c;
      r = by + STEP_BW'(py ^ by[0]);
      c = bx + STEP_BW'(px ^ bx[0]);
      return ADDR_BW'(r >> 1) * ADDR_BW'(BANK_COLS) + ADDR_BW'(c >> 1);
   endfunction

   // A stall re-reads the presented window so rdata stays stable next cycle.
   always_comb begin
      sel_y_c = win_oy;
      sel_x_c = win_ox;
      if (issue_c) begin
         sel_y_c = ny;
         sel_x_c = nx;
      end
      sram_raddr_a0 = bank_addr(sel_y_c, sel_x_c, 1'b0, 1'b0);
      sram_raddr_a1 = bank_addr(sel_y_c, sel_x_c, 1'b0, 1'b1);
      sram_raddr_a2 = bank_addr(sel_y_c, sel_x_c, 1'b1, 1'b0);
      sram_raddr_a3 = bank_addr(sel_y_c, sel_x_c, 1'b1, 1'b1);
      if (state == IDLE) begin
         sram_raddr_a0 = '0;
         sram_raddr_a1 = '0;
         sram_raddr_a2 = '0;
         sram_raddr_a3 = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_valid <= 1'b0;
         win_sel   <= '0;
         win_oy    <= '0;
         win_ox    <= '0;
         ny        <= '0;
         nx        <= '0;
         issued    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  win_valid <= 1'b0;
                  win_sel   <= '0;
                  win_oy    <= '0;
                  win_ox    <= '0;
                  ny        <= '0;
                  nx        <= '0;
                  issued    <= 1'b0;
               end
            end
            RUN: begin
               if (issue_c) begin
                  win_valid <= 1'b1;
                  win_oy    <= ny;
                  win_ox    <= nx;
                  win_sel   <= {ny[0], nx[0]};
                  if (nx == STEP_BW'(LAST_STEP)) begin
                     nx <= '0;
                     if (ny == STEP_BW'(LAST_STEP)) issued <= 1'b1;
                     else                           ny     <= ny + STEP_BW'(1);
                  end else begin
                     nx <= nx + STEP_BW'(1);
                  end
               end else if (accept_c) begin
                  win_valid <= 1'b0;
                  if (issued) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_read_sched.sv
// Bench for conv_read_sched: block-placement reference model, 4-bank SRAM image and
// an acceptance monitor; randomized ready patterns plus directed timing scenarios.
module tb_conv_read_sched;

   localparam int unsigned ADDR_BW = 6;
   localparam int unsigned STEP_BW = 3;
   localparam int          NSIDE   = 6;
   localparam int          NWIN    = 36;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic out_ready = 1'b0;
   logic busy, done, win_valid;
   logic [ADDR_BW-1:0] sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3;
   logic [1:0]         win_sel;
   logic [STEP_BW-1:0] win_oy, win_ox;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   conv_read_sched dut (
      .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
      .busy(busy), .done(done),
      .sram_raddr_a0(sram_raddr_a0), .sram_raddr_a1(sram_raddr_a1),
      .sram_raddr_a2(sram_raddr_a2), .sram_raddr_a3(sram_raddr_a3),
      .win_valid(win_valid), .win_sel(win_sel), .win_oy(win_oy), .win_ox(win_ox)
   );

   // Reference: a block (by,bx) sits in bank {by[0],bx[0]} at (by/2)*4 + bx/2.
   function automatic int blk_bank(int by, int bx);
      return (by % 2) * 2 + (bx % 2);
   endfunction

   function automatic int blk_addr(int by, int bx);
      return (by / 2) * 4 + (bx / 2);
   endfunction

   function automatic int exp_addr(int oy, int ox, int b);
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++)
            if (blk_bank(oy + dy, ox + dx) == b) return blk_addr(oy + dy, ox + dx);
      return -1;
   endfunction

   function automatic logic [23:0] exp_pack(int oy, int ox);
      return {6'(exp_addr(oy, ox, 0)), 6'(exp_addr(oy, ox, 1)),
              6'(exp_addr(oy, ox, 2)), 6'(exp_addr(oy, ox, 3))};
   endfunction

   function automatic logic [15:0] img_word(int b, int a);
      return 16'(b * 1000 + a * 37 + 4660);
   endfunction

   logic [23:0] got_addr;
   assign got_addr = {sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3};

   // SRAM group A image, read latency 1
   logic [15:0] rdata [4];
   always @(posedge clk) begin
      rdata[0] <= img_word(0, int'(sram_raddr_a0));
      rdata[1] <= img_word(1, int'(sram_raddr_a1));
      rdata[2] <= img_word(2, int'(sram_raddr_a2));
      rdata[3] <= img_word(3, int'(sram_raddr_a3));
   end

   // Acceptance/data monitor
   int acc_q[$];
   int done_cnt = 0;
   int data_err = 0;
   always @(posedge clk) begin
      if (!rst) begin
         if (win_valid) begin
            for (int b = 0; b < 4; b++)
               if (rdata[b] !== img_word(b, exp_addr(int'(win_oy), int'(win_ox), b)))
                  data_err <= data_err + 1;
         end
         if (win_valid && out_ready) acc_q.push_back(int'(win_oy) * NSIDE + int'(win_ox));
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   function automatic bit order_ok(int base);
      if (acc_q.size() - base != NWIN) return 1'b0;
      for (int i = 0; i < NWIN; i++)
         if (acc_q[base + i] != i) return 1'b0;
      return 1'b1;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_win(input int oy, input int ox, output bit found);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (win_valid === 1'b1 && int'(win_oy) == oy && int'(win_ox) == ox) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passes++;
      checks++; if (win_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", win_valid); else passes++;
      checks++; if ({win_sel, win_oy, win_ox} !== 8'h00)
         $display("FAIL reset_win got sel=%0d oy=%0d ox=%0d want 0", win_sel, win_oy, win_ox); else passes++;
      checks++; if (got_addr !== 24'h0) $display("FAIL reset_raddr got %h want 0", got_addr); else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_sweep();
      int base_acc, base_done, base_err;
      base_acc = acc_q.size(); base_done = done_cnt; base_err = data_err;
      out_ready = 1'b1;
      pulse_start();
      checks++; if (busy !== 1'b1 || win_valid !== 1'b0)
         $display("FAIL sweep_first busy=%0b valid=%0b want 1/0", busy, win_valid); else passes++;
      checks++; if (got_addr !== 24'h0) $display("FAIL sweep_addr00 got %h want 0", got_addr); else passes++;
      for (int j = 0; j < NWIN; j++) begin
         int oy, ox, ny, nx;
         @(negedge clk);
         oy = j / NSIDE; ox = j % NSIDE;
         ny = (j < NWIN - 1) ? (j + 1) / NSIDE : oy;
         nx = (j < NWIN - 1) ? (j + 1) % NSIDE : ox;
         checks++; if (win_valid !== 1'b1 || busy !== 1'b1 ||
                       {win_oy, win_ox} !== {STEP_BW'(oy), STEP_BW'(ox)})
            $display("FAIL sweep_win%0d got v=%0b oy=%0d ox=%0d want 1 %0d %0d", j, win_valid, win_oy, win_ox, oy, ox);
         else passes++;
         checks++; if (win_sel !== 2'(blk_bank(oy, ox)))
            $display("FAIL sweep_sel%0d got %0d want %0d", j, win_sel, blk_bank(oy, ox)); else passes++;
         checks++; if (got_addr !== exp_pack(ny, nx))
            $display("FAIL sweep_raddr%0d got %h want %h", j, got_addr, exp_pack(ny, nx)); else passes++;
         if (j + 1 == 8) begin
            checks++; if (got_addr !== {6'd5, 6'd5, 6'd1, 6'd1})
               $display("FAIL addr_1_2 got %h want 5,5,1,1", got_addr); else passes++;
         end
         if (j == 8) begin
            checks++; if (win_sel !== 2'b10) $display("FAIL sel_1_2 got %b want 10", win_sel); else passes++;
         end
         if (j == NWIN - 1) begin
            checks++; if (got_addr !== {6'd15, 6'd14, 6'd11, 6'd10} || win_sel !== 2'b11)
               $display("FAIL win_5_5 got addr=%h sel=%b want 15,14,11,10 sel 11", got_addr, win_sel);
            else passes++;
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b1 || busy !== 1'b1 || win_valid !== 1'b0)
         $display("FAIL sweep_done done=%0b busy=%0b valid=%0b want 1 1 0", done, busy, win_valid); else passes++;
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0 || got_addr !== 24'h0)
         $display("FAIL sweep_idle done=%0b busy=%0b addr=%h want 0 0 0", done, busy, got_addr); else passes++;
      checks++; if (!order_ok(base_acc)) $display("FAIL sweep_order got %0d accepts want 36 raster", acc_q.size() - base_acc); else passes++;
      checks++; if (done_cnt - base_done != 1) $display("FAIL sweep_donecnt got %0d want 1", done_cnt - base_done); else passes++;
      checks++; if (data_err != base_err) $display("FAIL sweep_rdata got %0d errors want 0", data_err - base_err); else passes++;
   endtask

   task automatic test_stall();
      int base_acc, base_done;
      bit found, ok;
      base_acc = acc_q.size(); base_done = done_cnt;
      out_ready = 1'b1;
      pulse_start();
      wait_win(2, 3, found);
      checks++; if (!found) $display("FAIL stall_reach got none want window 2,3"); else passes++;
      out_ready = 1'b0;
      #1;
      checks++; if (got_addr !== {6'd6, 6'd5, 6'd6, 6'd5} || got_addr !== exp_pack(2, 3))
         $display("FAIL stall_raddr0 got %h want 6,5,6,5", got_addr); else passes++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (win_valid !== 1'b1 || win_oy !== 3'd2 || win_ox !== 3'd3 ||
                       got_addr !== {6'd6, 6'd5, 6'd6, 6'd5})
            $display("FAIL stall_hold%0d got v=%0b oy=%0d ox=%0d addr=%h want 1 2 3 6,5,6,5", i, win_valid, win_oy, win_ox, got_addr);
         else passes++;
      end
      out_ready = 1'b1;
      #1;
      checks++; if (got_addr !== exp_pack(2, 4)) $display("FAIL stall_release got %h want %h", got_addr, exp_pack(2, 4)); else passes++;
      @(negedge clk);
      checks++; if (win_valid !== 1'b1 || win_oy !== 3'd2 || win_ox !== 3'd4)
         $display("FAIL stall_next got v=%0b oy=%0d ox=%0d want 1 2 4", win_valid, win_oy, win_ox); else passes++;
      wait_done(ok);
      checks++; if (!ok) $display("FAIL stall_done got timeout want done"); else passes++;
      @(negedge clk);
      checks++; if (!order_ok(base_acc)) $display("FAIL stall_order got %0d accepts want 36 raster", acc_q.size() - base_acc); else passes++;
      checks++; if (done_cnt - base_done != 1) $display("FAIL stall_donecnt got %0d want 1", done_cnt - base_done); else passes++;
   endtask

   task automatic test_random_ready();
      int base_acc, base_done, base_err;
      bit ok;
      base_acc = acc_q.size(); base_done = done_cnt; base_err = data_err;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (!ok) $display("FAIL rand_done got timeout want done"); else passes++;
      checks++; if (!order_ok(base_acc)) $display("FAIL rand_order got %0d accepts want 36 raster", acc_q.size() - base_acc); else passes++;
      checks++; if (done_cnt - base_done != 1) $display("FAIL rand_donecnt got %0d want 1", done_cnt - base_done); else passes++;
      checks++; if (data_err != base_err) $display("FAIL rand_rdata got %0d errors want 0", data_err - base_err); else passes++;
   endtask

   task automatic test_reset_mid();
      int base_acc, base_done;
      bit found, ok;
      out_ready = 1'b1;
      pulse_start();
      wait_win(3, 1, found);
      checks++; if (!found) $display("FAIL rmid_reach got none want window 3,1"); else passes++;
      base_done = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({busy, done, win_valid, win_sel, win_oy, win_ox} !== 11'h0 || got_addr !== 24'h0)
         $display("FAIL rmid_clear got busy=%0b done=%0b v=%0b sel=%0d oy=%0d ox=%0d addr=%h want all 0",
                  busy, done, win_valid, win_sel, win_oy, win_ox, got_addr);
      else passes++;
      repeat (5) @(negedge clk);
      checks++; if (done_cnt != base_done || busy !== 1'b0)
         $display("FAIL rmid_idle got dones=%0d busy=%0b want 0 0", done_cnt - base_done, busy); else passes++;
      base_acc = acc_q.size(); base_done = done_cnt;
      pulse_start();
      @(negedge clk);
      checks++; if (win_valid !== 1'b1 || win_oy !== 3'd0 || win_ox !== 3'd0)
         $display("FAIL rmid_restart got v=%0b oy=%0d ox=%0d want 1 0 0", win_valid, win_oy, win_ox); else passes++;
      wait_done(ok);
      @(negedge clk);
      checks++; if (!ok || !order_ok(base_acc))
         $display("FAIL rmid_sweep got done=%0b accepts=%0d want 1 36", ok, acc_q.size() - base_acc); else passes++;
      checks++; if (done_cnt - base_done != 1) $display("FAIL rmid_donecnt got %0d want 1", done_cnt - base_done); else passes++;
   endtask

   task automatic test_start_busy();
      int base_acc, base_done;
      bit found, ok;
      base_acc = acc_q.size(); base_done = done_cnt;
      out_ready = 1'b1;
      pulse_start();
      wait_win(1, 1, found);
      checks++; if (!found) $display("FAIL sbusy_reach got none want window 1,1"); else passes++;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (win_oy !== 3'd1 || win_ox !== 3'd2)
         $display("FAIL sbusy_next got oy=%0d ox=%0d want 1 2", win_oy, win_ox); else passes++;
      wait_done(ok);
      repeat (5) @(negedge clk);
      checks++; if (!ok || !order_ok(base_acc))
         $display("FAIL sbusy_sweep got done=%0b accepts=%0d want 1 36", ok, acc_q.size() - base_acc); else passes++;
      checks++; if (done_cnt - base_done != 1 || busy !== 1'b0)
         $display("FAIL sbusy_once got dones=%0d busy=%0b want 1 0", done_cnt - base_done, busy); else passes++;
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_stall();
      for (int r = 0; r < 4; r++) test_random_ready();
      test_reset_mid();
      test_start_busy();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
